// File: rtl/lcd_frame_scanner.sv
// Raster-order frame scanner: drives x/y to the bitmap generators, waits out the ROM latency,
// and hands one RGB565 word per pixel to the LCD writer. Define SCANNER_ABORT_EN to add an abort input.
module lcd_frame_scanner #(
    parameter int          WIDTH          = 240,
    parameter int          HEIGHT         = 320,
    parameter int          BITS_WIDTH     = 8,
    parameter int          BITS_HEIGHT    = 9,
    parameter int          BITMAP_LATENCY = 1,
    parameter logic [15:0] FG_COLOUR      = 16'hFFFF,
    parameter logic [15:0] BG_COLOUR      = 16'h0000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
`ifdef SCANNER_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   busy,
    output logic                   frameDone,
    output logic [BITS_WIDTH-1:0]  xAddLCD,
    output logic [BITS_HEIGHT-1:0] yAddLCD,
    input  logic                   bitmapPixEN,
    output logic [15:0]            pixelData,
    output logic                   pixelWrite,
    input  logic                   pixelReady
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_DONE} state_t;

    localparam logic [2:0]             LAT    = 3'(BITMAP_LATENCY);
    localparam logic [BITS_WIDTH-1:0]  X_LAST = BITS_WIDTH'(WIDTH - 1);
    localparam logic [BITS_HEIGHT-1:0] Y_LAST = BITS_HEIGHT'(HEIGHT - 1);

    state_t                   state_reg, state_next;
    logic [2:0]               cnt_reg, cnt_next;
    logic [BITS_WIDTH-1:0]    x_reg, x_next;
    logic [BITS_HEIGHT-1:0]   y_reg, y_next;
    logic [15:0]              data_reg, data_next;
    logic                     write_reg, write_next;
    logic                     busy_reg, busy_next;
    logic                     done_reg, done_next;
    logic                     abort_req;

`ifdef SCANNER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 3'd0;
            x_reg     <= '0;
            y_reg     <= '0;
            data_reg  <= BG_COLOUR;
            write_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            data_reg  <= data_next;
            write_reg <= write_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        data_next  = data_reg;
        write_next = write_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    x_next     = '0;
                    y_next     = '0;
                    cnt_next   = LAT;
                    busy_next  = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort_req) begin
                    x_next     = '0;
                    y_next     = '0;
                    busy_next  = 1'b0;
                    write_next = 1'b0;
                    state_next = S_IDLE;
                end else if (cnt_reg != 3'd0) begin
                    cnt_next = cnt_reg - 3'd1;
                end else begin
                    // Last WAIT cycle: the bitmap output now reflects the current address.
                    data_next  = bitmapPixEN ? FG_COLOUR : BG_COLOUR;
                    write_next = 1'b1;
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                // Abort wins over a same-cycle handshake, so that pixel is never counted.
                if (abort_req) begin
                    x_next     = '0;
                    y_next     = '0;
                    busy_next  = 1'b0;
                    write_next = 1'b0;
                    state_next = S_IDLE;
                end else if (pixelReady) begin
                    write_next = 1'b0;
                    cnt_next   = LAT;
                    if (x_reg == X_LAST && y_reg == Y_LAST) begin
                        done_next  = 1'b1;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_WAIT;
                        if (x_reg == X_LAST) begin
                            x_next = '0;
                            y_next = y_reg + BITS_HEIGHT'(1);
                        end else begin
                            x_next = x_reg + BITS_WIDTH'(1);
                        end
                    end
                end
            end
            default: begin
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy       = busy_reg;
    assign frameDone  = done_reg;
    assign xAddLCD    = x_reg;
    assign yAddLCD    = y_reg;
    assign pixelData  = data_reg;
    assign pixelWrite = write_reg;

endmodule

// File: tb/tb_lcd_frame_scanner.sv
// Bench for lcd_frame_scanner on a 4x3 frame: table-driven frames with a pixel scoreboard,
// plus hand-written start re-pulse, async reset and (with SCANNER_ABORT_EN) abort sequences.
module tb_lcd_frame_scanner;

    localparam int          W   = 4;
    localparam int          H   = 3;
    localparam int          LAT = 1;
    localparam logic [15:0] FG  = 16'hFFFF;
    localparam logic [15:0] BG  = 16'h0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, frameDone, pixelWrite;
    logic [7:0]  xAddLCD;
    logic [8:0]  yAddLCD;
    logic        bitmapPixEN;
    logic [15:0] pixelData;
    logic        pixelReady = 1'b1;
`ifdef SCANNER_ABORT_EN
    logic        abort = 1'b0;
`endif

    lcd_frame_scanner #(.WIDTH(W), .HEIGHT(H), .BITMAP_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .start(start),
`ifdef SCANNER_ABORT_EN
        .abort(abort),
`endif
        .busy(busy), .frameDone(frameDone), .xAddLCD(xAddLCD), .yAddLCD(yAddLCD),
        .bitmapPixEN(bitmapPixEN), .pixelData(pixelData), .pixelWrite(pixelWrite),
        .pixelReady(pixelReady)
    );

    always #5 clock = ~clock;

    // Bitmap generator stand-in: one-cycle ROM latency, lit only at (hx,hy).
    int   hx = 0, hy = 0;
    bit   hon = 1'b0;
    logic rom_q = 1'b0;
    always @(posedge clock) rom_q <= hon && (xAddLCD == 8'(hx)) && (yAddLCD == 9'(hy));
    assign bitmapPixEN = rom_q;

    typedef struct { logic [7:0] x; logic [8:0] y; logic [15:0] d; } exp_t;
    typedef struct {
        bit hit_on; int hit_x; int hit_y;
        int stall_x; int stall_y; int stall_len;
        int exp_cycles; int exp_fg;
    } vec_t;

    exp_t sb[$];
    int   n_checks = 0, n_fail = 0;
    int   writes = 0, fg_seen = 0;
    int   stall_x = 0, stall_y = 0, stall_len = 0, stall_cnt = 0;
    bit   prev_write = 1'b0, prev_ready = 1'b1, aborting = 1'b0, abort_armed = 1'b0;
    int   ax = 0, ay = 0;
    logic [7:0]  px;
    logic [8:0]  py;
    logic [15:0] pd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input bit on, input int tx, input int ty, input int count);
        exp_t e;
        int   k;
        k = 0;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                if (k < count) begin
                    e.x = 8'(x);
                    e.y = 9'(y);
                    e.d = (on && x == tx && y == ty) ? FG : BG;
                    sb.push_back(e);
                end
                k++;
            end
    endtask

    // One negedge: hold check, pick pixelReady/abort for the next edge, score any handshake.
    task automatic step();
        exp_t e;
        @(negedge clock);
        if (reset) begin
            prev_write = 1'b0;
            pixelReady = 1'b1;
            return;
        end
        if (prev_write && !prev_ready)
            check("stall_hold", {pixelWrite, xAddLCD, yAddLCD, pixelData}, {1'b1, px, py, pd});
`ifdef SCANNER_ABORT_EN
        abort = 1'b0;
        if (abort_armed && pixelWrite && xAddLCD == 8'(ax) && yAddLCD == 9'(ay)) begin
            abort       = 1'b1;
            abort_armed = 1'b0;
            aborting    = 1'b1;
        end
`endif
        if (pixelWrite && !aborting && xAddLCD == 8'(stall_x) && yAddLCD == 9'(stall_y)
            && stall_cnt < stall_len) begin
            pixelReady = 1'b0;
            stall_cnt++;
        end else begin
            pixelReady = 1'b1;
        end
        if (pixelWrite && pixelReady && !aborting) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                check("pixel", {xAddLCD, yAddLCD, pixelData}, {e.x, e.y, e.d});
            end
            writes++;
            if (pixelData == FG) fg_seen++;
        end
        prev_write = pixelWrite;
        prev_ready = pixelReady;
        px = xAddLCD;
        py = yAddLCD;
        pd = pixelData;
    endtask

    task automatic run_frame(input vec_t v, input bit repulse);
        int  cyc;
        bit  done_seen, pulsed;
        hon = v.hit_on; hx = v.hit_x; hy = v.hit_y;
        stall_x = v.stall_x; stall_y = v.stall_y; stall_len = v.stall_len; stall_cnt = 0;
        writes = 0; fg_seen = 0; pulsed = 1'b0; done_seen = 1'b0;
        push_frame(v.hit_on, v.hit_x, v.hit_y, W * H);
        step();
        start = 1'b1;
        cyc = 1;
        step();
        start = 1'b0;
        cyc = 2;
        check("busy_rise", busy, 1'b1);
        for (int i = 0; i < 2000 && !done_seen; i++) begin
            if (frameDone) begin
                done_seen = 1'b1;
                check("done_cycle", 64'(cyc), 64'(v.exp_cycles));
            end else begin
                if (repulse && writes == 5 && !pulsed) begin
                    start  = 1'b1;
                    pulsed = 1'b1;
                end else begin
                    start = 1'b0;
                end
                step();
                cyc++;
            end
        end
        if (!done_seen) check("done_timeout", 64'd0, 64'd1);
        start = repulse;
        step();
        start = 1'b0;
        check("done_single", frameDone, 1'b0);
        check("busy_fall", busy, 1'b0);
        check("write_count", 64'(writes), 64'(W * H));
        check("fg_count", 64'(fg_seen), 64'(v.exp_fg));
        check("sb_empty", 64'(sb.size()), 64'd0);
        if (repulse)
            for (int i = 0; i < 3; i++) begin
                step();
                check("start_ignored", {busy, pixelWrite}, 2'b00);
            end
    endtask

    vec_t vecs[4];
    vec_t plain;

    initial begin
        vecs[0] = '{1'b0, 0, 0, 0, 0, 0, W*H*(LAT+2)+2, 0};
        vecs[1] = '{1'b1, 2, 1, 0, 0, 0, W*H*(LAT+2)+2, 1};
        vecs[2] = '{1'b1, 3, 2, 1, 0, 5, W*H*(LAT+2)+2+5, 1};
        vecs[3] = '{1'b1, 0, 0, 3, 2, 2, W*H*(LAT+2)+2+2, 1};
        plain   = vecs[0];

        #2;
        check("reset_state", {busy, frameDone, pixelWrite, xAddLCD, yAddLCD, pixelData},
              {1'b0, 1'b0, 1'b0, 8'd0, 9'd0, BG});
        step();
        step();
        reset = 1'b0;
        step();
        check("idle_quiet", {busy, frameDone, pixelWrite}, 3'b000);

        for (int i = 0; i < 4; i++) run_frame(vecs[i], 1'b0);

        // start re-pulsed mid-frame and on the frameDone cycle, then a fresh frame.
        run_frame(plain, 1'b1);
        run_frame(plain, 1'b0);

        // Async reset while pixel (3,1) is held in WRITE.
        hon = 1'b0; stall_x = 3; stall_y = 1; stall_len = 1000; stall_cnt = 0; writes = 0;
        push_frame(1'b0, 0, 0, W * H);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 500 && !(pixelWrite && xAddLCD == 8'd3 && yAddLCD == 9'd1); i++) step();
        check("reached_3_1", {pixelWrite, xAddLCD, yAddLCD}, {1'b1, 8'd3, 9'd1});
        #2 reset = 1'b1;
        #1;
        check("async_reset", {busy, frameDone, pixelWrite, xAddLCD, yAddLCD, pixelData},
              {1'b0, 1'b0, 1'b0, 8'd0, 9'd0, BG});
        check("writes_before_reset", 64'(writes), 64'd7);
        sb.delete();
        stall_len = 0;
        step();
        reset = 1'b0;
        begin
            int dones = 0;
            for (int i = 0; i < 6; i++) begin
                step();
                if (frameDone || busy) dones++;
            end
            check("no_done_after_reset", 64'(dones), 64'd0);
        end
        run_frame(plain, 1'b0);

`ifdef SCANNER_ABORT_EN
        // Abort during WRITE of (0,2) with pixelReady high: that pixel must not count.
        hon = 1'b0; stall_len = 0; stall_cnt = 0; writes = 0;
        ax = 0; ay = 2; abort_armed = 1'b1; aborting = 1'b0;
        push_frame(1'b0, 0, 0, 8);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 500 && !aborting; i++) step();
        check("abort_fired", aborting, 1'b1);
        step();
        aborting = 1'b0;
        check("abort_state", {busy, frameDone, pixelWrite, xAddLCD, yAddLCD}, {3'b000, 8'd0, 9'd0});
        check("abort_writes", 64'(writes), 64'd8);
        check("abort_sb_empty", 64'(sb.size()), 64'd0);
        for (int i = 0; i < 4; i++) step();
        check("abort_no_done", {busy, frameDone}, 2'b00);
        run_frame(plain, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
